// File: rtl/reg_dump_serializer.sv
// reg_dump_serializer: snapshots a flat register file and streams it as a
// byte frame (header, data MSB-first from register 0, XOR checksum) over valid/ready.
module reg_dump_serializer #(
    parameter int         DATA_WIDTH = 32,
    parameter int         NUM_REGS   = 32,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [DATA_WIDTH*NUM_REGS-1:0] registers,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           busy,
    output logic                           done
);
    localparam int W  = DATA_WIDTH * NUM_REGS;
    localparam int NB = W / 8;
    localparam int CW = $clog2(NB);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_CHECK, S_DONE} state_t;

    state_t        state, state_n;
    logic [W-1:0]  snap, snap_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    acc, acc_n, data_n;
    logic          xfer, last, active_n;

    assign xfer = tx_valid && tx_ready;
    assign last = cnt == CW'(NB - 1);

    always_comb begin
        state_n = state;
        snap_n  = snap;
        cnt_n   = cnt;
        acc_n   = acc;
        data_n  = tx_data;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_HEADER;
                snap_n  = registers;
                cnt_n   = '0;
                acc_n   = '0;
                data_n  = HEADER;
            end
            S_HEADER: if (xfer) begin
                state_n = S_DATA;
                data_n  = snap[W-1 -: 8];
            end
            // the byte on the wire is always the top byte of snap, so the next one sits just below it
            S_DATA: if (xfer) begin
                state_n = last ? S_CHECK : S_DATA;
                snap_n  = snap << 8;
                acc_n   = acc ^ tx_data;
                cnt_n   = cnt + 1'b1;
                data_n  = last ? acc ^ tx_data : snap[W-9 -: 8];
            end
            S_CHECK: if (xfer) begin
                state_n = S_DONE;
                data_n  = '0;
            end
            default: state_n = S_IDLE;
        endcase
        active_n = state_n inside {S_HEADER, S_DATA, S_CHECK};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            snap     <= '0;
            cnt      <= '0;
            acc      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            snap     <= snap_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            tx_data  <= data_n;
            tx_valid <= active_n;
            busy     <= active_n;
            done     <= state_n == S_DONE;
        end
    end
endmodule

// File: doc/reg_dump_serializer.md
REG_DUMP_SERIALIZER -- requirements
Module: reg_dump_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one architectural register.
REQ-002 Parameter NUM_REGS, default 32, number of registers in the flat register-file bus.
REQ-003 Parameter HEADER, default 8'hA5, frame start byte.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-low; sampled on posedge clk.
REQ-006 start  input  1  dump request, sampled only in IDLE.
REQ-007 registers  input  DATA_WIDTH*NUM_REGS (1024)  flat register-file contents; register 0 occupies bits [1023:992], register 31 occupies bits [31:0].
REQ-008 tx_data  output  8  current byte offered downstream.
REQ-009 tx_valid  output  1  tx_data holds a valid byte.
REQ-010 tx_ready  input  1  downstream accepts the byte this cycle.
REQ-011 busy  output  1  a frame is in progress (HEADER, DATA or CHECK).
REQ-012 done  output  1  single-cycle pulse after the last frame byte is accepted.

Function
REQ-013 The FSM SHALL have the states IDLE, HEADER, DATA, CHECK and DONE; all outputs are registered.
REQ-014 A transfer SHALL occur on any posedge where tx_valid=1 and tx_ready=1.
REQ-015 IDLE with start=1 SHALL capture registers into a 1024-bit snapshot register, clear the byte counter and XOR accumulator, and go to HEADER; tx_valid=1 and tx_data=HEADER on the next cycle.
REQ-016 HEADER: on transfer -> DATA; tx_data = snapshot[1023:1016].
REQ-017 DATA: each transfer SHALL shift the snapshot left by 8, XOR the sent byte into the accumulator and increment a 7-bit byte counter; byte order is register 0 first, MSB byte first.
REQ-018 DATA: a transfer with counter=127 (the 128th data byte) -> CHECK; tx_data = final XOR of all 128 data bytes.
REQ-019 CHECK: on transfer -> DONE; tx_valid=0.
REQ-020 DONE SHALL last exactly one cycle with done=1, then -> IDLE.
REQ-021 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0; tx_valid SHALL never deassert before a transfer.
REQ-022 busy=1 in HEADER, DATA and CHECK, 0 in IDLE and DONE.
REQ-023 start SHALL be ignored outside IDLE; start in DONE does not begin a frame (earliest new capture is the cycle after DONE).
REQ-024 Changes on registers after capture SHALL NOT affect the frame in progress.
REQ-025 A frame SHALL be exactly 130 bytes (header, 128 data, checksum).
REQ-026 With tx_ready held at 1 and start at cycle N: header at N+1, data bytes at N+2..N+129, checksum at N+130, done at N+131.
REQ-027 tx_ready is ignored when tx_valid=0.

Reset
REQ-028 reset=0 at a posedge SHALL force IDLE, tx_valid=0, tx_data=0, busy=0, done=0, counter=0, accumulator=0 and snapshot=0, overriding start and any state.
REQ-029 Reset mid-frame SHALL abort the frame without a done pulse; the next frame after reset release starts afresh with HEADER.
REQ-030 While reset=0, start is ignored.

Verification
REQ-031 Reg i = 32'h01010101*i, tx_ready=1, start pulse at cycle 10 -> A5 at cycle 11, bytes 00,00,00,00,01,01,01,01,...,1F,1F,1F,1F, checksum 00, done at cycle 141.
REQ-032 Reg 0 = 32'hDEADBEEF, others 0 -> data bytes DE,AD,BE,EF then 124×00, checksum 8'hDE^AD^BE^EF = 8'h22.
REQ-033 tx_ready random 30% duty -> identical 130-byte sequence as REQ-031, tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-034 registers driven to all-ones one cycle after start -> frame still carries the captured values; start pulses during busy and DONE produce no extra frame.
REQ-035 reset=0 for one cycle after data byte 50 -> outputs zeroed next cycle, no done; new start -> full 130-byte frame beginning A5.
REQ-036 tx_ready=0 permanently after start -> tx_valid=1, tx_data=A5 held indefinitely, busy=1.
